// File: rtl/timer_dev.sv
// Memory-mapped down-counting timer with one-shot and auto-reload modes.
// CTRL/PRESET/COUNT are decoded from addr[3:2]; irq is the sticky flag gated by CTRL.IM.
module timer_dev #(
    parameter int unsigned MODE_W = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] addr,
    input  logic [31:0] dIn,
    input  logic        ifWr,
    output logic [31:0] dOut,
    output logic        irq
);

    typedef enum logic [1:0] {StIdle, StLoad, StCnt, StInt} state_e;

    state_e              state_q, state_d;
    logic                en_q, en_d;
    logic [MODE_W-1:0]   mode_q, mode_d;
    logic                im_q, im_d;
    logic [31:0]         preset_q, preset_d;
    logic [31:0]         count_q, count_d;
    logic                flag_q, flag_d;
    logic [31:0]         ctrl_rd;

    logic unused_addr;
    assign unused_addr = ^{addr[31:4], addr[1:0]};

    always_comb begin
        state_d  = state_q;
        en_d     = en_q;
        mode_d   = mode_q;
        im_d     = im_q;
        preset_d = preset_q;
        count_d  = count_q;
        flag_d   = flag_q;

        unique case (state_q)
            StIdle: begin
                if (en_q) state_d = StLoad;
            end
            StLoad: begin
                count_d = preset_q;
                state_d = StCnt;
            end
            StCnt: begin
                if (!en_q) begin
                    state_d = StIdle;
                end else if (count_q > 32'd1) begin
                    count_d = count_q - 32'd1;
                end else begin
                    // PRESET=0 also lands here, so it times like PRESET=1
                    count_d = '0;
                    state_d = StInt;
                    flag_d  = 1'b1;
                end
            end
            StInt: begin
                if (mode_q == MODE_W'(1)) begin
                    flag_d  = 1'b0;
                    state_d = en_q ? StLoad : StIdle;
                end else begin
                    en_d    = 1'b0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // CPU writes come last so they win over hardware updates on the same edge
        if (ifWr) begin
            unique case (addr[3:2])
                2'd0: begin
                    en_d   = dIn[0];
                    mode_d = dIn[MODE_W:1];
                    im_d   = dIn[MODE_W+1];
                    flag_d = 1'b0;
                end
                2'd1: begin
                    preset_d = dIn;
                    flag_d   = 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= StIdle;
            en_q     <= 1'b0;
            mode_q   <= '0;
            im_q     <= 1'b0;
            preset_q <= '0;
            count_q  <= '0;
            flag_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            en_q     <= en_d;
            mode_q   <= mode_d;
            im_q     <= im_d;
            preset_q <= preset_d;
            count_q  <= count_d;
            flag_q   <= flag_d;
        end
    end

    always_comb begin
        ctrl_rd             = '0;
        ctrl_rd[0]          = en_q;
        ctrl_rd[MODE_W:1]   = mode_q;
        ctrl_rd[MODE_W+1]   = im_q;
        unique case (addr[3:2])
            2'd0:    dOut = ctrl_rd;
            2'd1:    dOut = preset_q;
            2'd2:    dOut = count_q;
            default: dOut = '0;
        endcase
    end

    assign irq = flag_q & im_q;

endmodule

// File: tb/tb_timer_dev.sv
// Bench for timer_dev: directed vector table, async-reset sequences, and a
// randomized run against a cycle-level behavioural model.
module tb_timer_dev;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] addr;
    logic [31:0] dIn;
    logic        ifWr;
    logic [31:0] dOut;
    logic        irq;

    int total = 0;
    int bad   = 0;

    timer_dev dut (
        .clk     (clk),
        .reset_n (reset_n),
        .addr    (addr),
        .dIn     (dIn),
        .ifWr    (ifWr),
        .dOut    (dOut),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          wr;
        bit [1:0]    waddr;
        logic [31:0] wdata;
        bit [1:0]    raddr;
        logic [31:0] exp;
        bit          exp_irq;
    } vec_t;

    vec_t tbl[$];

    task automatic row(input bit wr, input bit [1:0] wa, input logic [31:0] wd,
                       input bit [1:0] ra, input logic [31:0] ex, input bit ei);
        vec_t v;
        v.wr = wr; v.waddr = wa; v.wdata = wd; v.raddr = ra; v.exp = ex; v.exp_irq = ei;
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wr_reg(input bit [1:0] a, input logic [31:0] d);
        @(negedge clk);
        addr = {28'h0, a, 2'b00};
        dIn  = d;
        ifWr = 1'b1;
        @(posedge clk);
        #1;
        ifWr = 1'b0;
    endtask

    // Behavioural model: one record of architectural state, advanced once per edge.
    typedef struct {
        bit          en;
        int          mode;
        bit          im;
        logic [31:0] preset;
        logic [31:0] count;
        bit          flag;
        int          phase; // 0 idle, 1 load, 2 counting, 3 expired
    } mst_t;

    function automatic mst_t mstep(input mst_t s, input bit wr, input int ra,
                                   input logic [31:0] d);
        mst_t n = s;
        if (s.phase == 0) begin
            if (s.en) n.phase = 1;
        end else if (s.phase == 1) begin
            n.count = s.preset;
            n.phase = 2;
        end else if (s.phase == 2) begin
            if (!s.en) n.phase = 0;
            else if (s.count > 1) n.count = s.count - 1;
            else begin
                n.count = 0;
                n.phase = 3;
                n.flag  = 1;
            end
        end else begin
            if (s.mode == 1) begin
                n.flag  = 0;
                n.phase = s.en ? 1 : 0;
            end else begin
                n.en    = 0;
                n.phase = 0;
            end
        end
        if (wr && ra == 0) begin
            n.en = d[0]; n.mode = int'(d[2:1]); n.im = d[3]; n.flag = 0;
        end
        if (wr && ra == 1) begin
            n.preset = d; n.flag = 0;
        end
        return n;
    endfunction

    function automatic logic [31:0] mread(input mst_t s, input int a);
        case (a)
            0:       return 32'(s.en) | (32'(s.mode) << 1) | (32'(s.im) << 3);
            1:       return s.preset;
            2:       return s.count;
            default: return 32'h0;
        endcase
    endfunction

    initial begin
        mst_t        m;
        logic [31:0] r;
        int          a;
        bit          w;
        logic [31:0] d;

        reset_n = 1'b0;
        ifWr    = 1'b0;
        addr    = '0;
        dIn     = '0;

        // one-shot, then irq clear
        row(1, 1, 3, 1, 3, 0);
        row(1, 0, 9, 0, 9, 0);
        row(0, 0, 0, 2, 0, 0);
        row(0, 0, 0, 2, 3, 0);
        row(0, 0, 0, 2, 2, 0);
        row(0, 0, 0, 2, 1, 0);
        row(0, 0, 0, 2, 0, 1);
        row(0, 0, 0, 0, 8, 1);
        row(0, 0, 0, 0, 8, 1);
        row(1, 0, 0, 0, 0, 0);
        row(0, 0, 0, 2, 0, 0);
        // auto-reload, period 4, then stopped
        row(1, 1, 2, 1, 2, 0);
        row(1, 0, 32'hB, 0, 32'hB, 0);
        row(0, 0, 0, 2, 0, 0);
        row(0, 0, 0, 2, 2, 0);
        row(0, 0, 0, 2, 1, 0);
        row(0, 0, 0, 2, 0, 1);
        row(0, 0, 0, 2, 0, 0);
        row(0, 0, 0, 2, 2, 0);
        row(0, 0, 0, 2, 1, 0);
        row(0, 0, 0, 2, 0, 1);
        row(0, 0, 0, 2, 0, 0);
        row(1, 0, 0, 2, 2, 0);
        row(0, 0, 0, 2, 2, 0);
        row(0, 0, 0, 2, 2, 0);
        // masked one-shot
        row(1, 0, 1, 0, 1, 0);
        row(0, 0, 0, 2, 2, 0);
        row(0, 0, 0, 2, 2, 0);
        row(0, 0, 0, 2, 1, 0);
        row(0, 0, 0, 2, 0, 0);
        row(0, 0, 0, 0, 0, 0);
        // disable mid-count freezes COUNT
        row(1, 1, 5, 1, 5, 0);
        row(1, 0, 1, 0, 1, 0);
        row(0, 0, 0, 2, 0, 0);
        row(0, 0, 0, 2, 5, 0);
        row(0, 0, 0, 2, 4, 0);
        row(1, 0, 0, 2, 3, 0);
        row(0, 0, 0, 2, 3, 0);
        row(0, 0, 0, 2, 3, 0);
        // PRESET=0 and ignored writes
        row(1, 1, 0, 1, 0, 0);
        row(1, 0, 9, 0, 9, 0);
        row(0, 0, 0, 2, 3, 0);
        row(0, 0, 0, 2, 0, 0);
        row(0, 0, 0, 2, 0, 1);
        row(0, 0, 0, 0, 8, 1);
        row(1, 2, 32'h55, 2, 0, 1);
        row(1, 3, 32'hFFFF_FFFF, 3, 0, 1);
        row(0, 0, 0, 1, 0, 1);
        row(0, 0, 0, 0, 8, 1);
        row(1, 1, 7, 1, 7, 0);

        #12;
        for (int i = 0; i < 4; i++) begin
            addr = 32'(i) << 2;
            #1 chk($sformatf("reset_read%0d", i), dOut, 32'h0);
        end
        chk("reset_irq", 32'(irq), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            addr = {28'h0, tbl[i].waddr, 2'b00};
            dIn  = tbl[i].wdata;
            ifWr = tbl[i].wr;
            @(posedge clk);
            #1;
            ifWr = 1'b0;
            dIn  = '0;
            addr = {28'h0, tbl[i].raddr, 2'b00};
            #1;
            chk($sformatf("vec%0d_read", i), dOut, tbl[i].exp);
            chk($sformatf("vec%0d_irq", i), 32'(irq), 32'(tbl[i].exp_irq));
        end

        // held irq drops asynchronously with reset
        wr_reg(1, 0);
        wr_reg(0, 9);
        repeat (4) @(posedge clk);
        #1 chk("irq_before_reset", 32'(irq), 32'h1);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1 chk("irq_async_reset", 32'(irq), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;

        // reset mid-count abandons the count
        wr_reg(1, 7);
        wr_reg(0, 9);
        repeat (4) @(posedge clk);
        #1 addr = 32'h8;
        #1 chk("count_mid", dOut, 32'd5);
        @(negedge clk);
        #2 reset_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            addr = 32'(i) << 2;
            #1 chk($sformatf("midreset_read%0d", i), dOut, 32'h0);
        end
        chk("midreset_irq", 32'(irq), 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (12) @(negedge clk);
        chk("post_reset_irq", 32'(irq), 32'h0);
        addr = 32'h8;
        #1 chk("post_reset_count", dOut, 32'h0);
        addr = 32'h0;
        #1 chk("post_reset_ctrl", dOut, 32'h0);

        // randomized run against the model, starting from a fresh reset
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        m = '{en: 0, mode: 0, im: 0, preset: 0, count: 0, flag: 0, phase: 0};
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            a = $urandom_range(0, 3);
            w = ($urandom_range(0, 7) == 0);
            if (a == 1) d = 32'($urandom_range(0, 6));
            else begin
                d = $urandom;
                if ($urandom_range(0, 3) != 0) d[0] = 1'b1;
            end
            r    = $urandom;
            addr = {r[31:4], a[1:0], r[1:0]};
            dIn  = d;
            ifWr = w;
            #1;
            chk($sformatf("rnd%0d_read", c), dOut, mread(m, a));
            chk($sformatf("rnd%0d_irq", c), 32'(irq), 32'(m.flag & m.im));
            @(posedge clk);
            m = mstep(m, w, a, d);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
